fp_mul_sched: RTL

Round-robin scheduler sharing one combinational IEEE-754 single-precision multiplier between N_REQ requesters. Each requester gets a valid/ready request channel and a valid/ready response channel. The block registers the granted operands, drives the shared multiplier, captures its result, and returns it to the owner. It also forces signed-zero results for zero/denormal operands, which the multiplier cannot produce.

---
 rtl/fp_mul_sched_pkg.sv | 19 +
 rtl/fp_mul_sched_rr_arbiter.sv | 31 +++
 rtl/fp_mul_sched.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fp_mul_sched_pkg.sv
// Shared types and helpers for the round-robin FP32 multiplier scheduler.
package fp_mul_sched_pkg;

  localparam int FP_W  = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // True for zero and denormal encodings, which the shared multiplier mishandles.
  function automatic logic is_zero_exp(input logic [FP_W-1:0] fp);
    return fp[MAN_W +: EXP_W] == '0;
  endfunction

endpackage

// File: rtl/fp_mul_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr with wrap, one-hot grant.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            en,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  int   idx;
  logic found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fp_mul_sched.sv
// Shares one external combinational FP32 multiplier between N_REQ requesters,
// round-robin, with a signed-zero bypass for zero/denormal operands.
module fp_mul_sched
  import fp_mul_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [FP_W*N_REQ-1:0] req_a,
  input  logic [FP_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      resp_valid,
  input  logic [N_REQ-1:0]      resp_ready,
  output logic [FP_W-1:0]       resp_c,
  output logic [FP_W-1:0]       mul_a,
  output logic [FP_W-1:0]       mul_b,
  input  logic [FP_W-1:0]       mul_c,
  output logic                  busy,
  output logic [ID_W-1:0]       grant_id,
  output logic [15:0]           op_count
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [FP_W-1:0]   mul_a_q, mul_a_d;
  logic [FP_W-1:0]   mul_b_q, mul_b_d;
  logic [FP_W-1:0]   resp_c_q, resp_c_d;
  logic [15:0]       op_count_q, op_count_d;

  logic              arb_en;
  logic [N_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]   arb_id;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .en     (arb_en),
    .gnt    (arb_gnt),
    .gnt_id (arb_id)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    resp_c_d   = resp_c_q;
    op_count_d = op_count_q;
    arb_en     = 1'b0;
    resp_valid = '0;

    case (state_q)
      IDLE: begin
        // Gated by rst_n so req_ready reads zero while reset is held.
        arb_en = rst_n;
      end
      ISSUE: begin
        if (is_zero_exp(mul_a_q) || is_zero_exp(mul_b_q)) begin
          resp_c_d = {mul_a_q[FP_W-1] ^ mul_b_q[FP_W-1], {(FP_W-1){1'b0}}};
        end else begin
          resp_c_d = mul_c;
        end
        state_d = RESP;
      end
      RESP: begin
        resp_valid[grant_id_q] = 1'b1;
        if (resp_ready[grant_id_q]) begin
          arb_en     = rst_n;
          op_count_d = op_count_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Common grant path for IDLE and the RESP handshake cycle (back-to-back).
    if (|arb_gnt) begin
      mul_a_d    = req_a[FP_W*int'(arb_id) +: FP_W];
      mul_b_d    = req_b[FP_W*int'(arb_id) +: FP_W];
      grant_id_d = arb_id;
      ptr_d      = (arb_id == ID_W'(N_REQ-1)) ? '0 : arb_id + 1'b1;
      state_d    = ISSUE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_id_q <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      resp_c_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_id_q <= grant_id_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      resp_c_q   <= resp_c_d;
      op_count_q <= op_count_d;
    end
  end

  assign req_ready = arb_gnt;
  assign resp_c    = resp_c_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_id_q;
  assign op_count  = op_count_q;

endmodule
